// File: rtl/sevenseg_mux_ctrl.sv
// Time-multiplexed seven-segment controller: per-digit hex/dp/blank register file,
// programmable refresh scan with a dead cycle at each digit switch and leading-zero blanking.
module sevenseg_mux_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_DIV    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_sel,
    input  logic [3:0]                    wr_data,
    input  logic                          wr_dp,
    input  logic                          wr_blank,
    input  logic                          clr,
    input  logic                          lz_en,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done
);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'b1111110;
            4'h1:    hex_to_seg = 7'b0110000;
            4'h2:    hex_to_seg = 7'b1101101;
            4'h3:    hex_to_seg = 7'b1111001;
            4'h4:    hex_to_seg = 7'b0110011;
            4'h5:    hex_to_seg = 7'b1011011;
            4'h6:    hex_to_seg = 7'b1011111;
            4'h7:    hex_to_seg = 7'b1110000;
            4'h8:    hex_to_seg = 7'b1111111;
            4'h9:    hex_to_seg = 7'b1111011;
            4'hA:    hex_to_seg = 7'b1110111;
            4'hB:    hex_to_seg = 7'b0011111;
            4'hC:    hex_to_seg = 7'b1001110;
            4'hD:    hex_to_seg = 7'b0111101;
            4'hE:    hex_to_seg = 7'b1001111;
            default: hex_to_seg = 7'b1000111;
        endcase
    endfunction

    logic [3:0]            val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dpb_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_q, frame_d;
    logic                  tick, last_idx;
    logic [NUM_DIGITS-1:0] sup, an_hot;
    logic                  lz_run, dark;

    // Write wins over clear for the addressed entry; out-of-range selects match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) val_q[i] <= 4'd0;
            dpb_q   <= '0;
            blank_q <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_en && (wr_sel == SW'(i))) begin
                    val_q[i]   <= wr_data;
                    dpb_q[i]   <= wr_dp;
                    blank_q[i] <= wr_blank;
                end else if (clr) begin
                    val_q[i]   <= 4'd0;
                    dpb_q[i]   <= 1'b0;
                    blank_q[i] <= 1'b0;
                end
            end
        end
    end

    assign tick     = (cnt_q == CW'(REFRESH_DIV - 1));
    assign last_idx = (idx_q == SW'(NUM_DIGITS - 1));

    // A digit is suppressed while every digit from the top down to it is an unblanked zero.
    always_comb begin
        lz_run = 1'b1;
        sup    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run & (val_q[i] == 4'd0) & ~blank_q[i];
            if (i != 0) sup[i] = lz_run & lz_en;
        end
    end

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        if (tick) idx_d = last_idx ? '0 : idx_q + 1'b1;
        frame_d = tick & last_idx;
        an_hot  = '0;
        an_hot[idx_q] = 1'b1;
        dark    = blank_q[idx_q] | sup[idx_q];
        if (tick) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = SEG_ACTIVE_LOW;
        end else begin
            an_d  = an_hot ^ AN_OFF;
            seg_d = (dark ? 7'd0 : hex_to_seg(val_q[idx_q])) ^ SEG_OFF;
            dp_d  = dpb_q[idx_q] ^ SEG_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_ACTIVE_LOW;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_q;
endmodule

// File: tb/tb_sevenseg_mux_ctrl.sv
// Scoreboard bench: an 8-digit and a 6-digit controller share stimulus; a slot-arithmetic
// reference model predicts every registered output, a monitor checks each cycle.
module tb_sevenseg_mux_ctrl;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst, wr_en, wr_dp, wr_blank, clr, lz_en;
    logic [2:0] wr_sel;
    logic [3:0] wr_data;
    logic [6:0] seg8, seg6;
    logic       dp8, dp6, fd8, fd6;
    logic [7:0] an8;
    logic [5:0] an6;

    always #5 clk = ~clk;

    sevenseg_mux_ctrl #(.NUM_DIGITS(8), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut8 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .clr(clr), .lz_en(lz_en), .seg(seg8), .dp(dp8), .an(an8), .frame_done(fd8));

    sevenseg_mux_ctrl #(.NUM_DIGITS(6), .REFRESH_DIV(R), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_blank(wr_blank), .clr(clr), .lz_en(lz_en), .seg(seg6), .dp(dp6), .an(an6), .frame_done(fd6));

    typedef struct {
        logic [7:0] an8;
        logic [6:0] seg8;
        logic       dp8, fd8;
        logic [5:0] an6;
        logic [6:0] seg6;
        logic       dp6, fd6;
        int         k;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;

    logic [3:0] mval [2][16];
    bit         mdp  [2][16];
    bit         mbl  [2][16];
    logic [6:0] dec_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Edge k (1-based since reset release) sits at position (k-1)%R of slot (k-1)/R.
    function automatic void model_out(input int inst, output logic [15:0] a, output logic [6:0] s,
                                      output logic d, output logic f);
        int n, p, dig;
        bit dark, allz;
        n   = (inst == 0) ? 8 : 6;
        p   = (k - 1) % R;
        dig = ((k - 1) / R) % n;
        a   = '1;
        s   = '1;
        d   = 1'b1;
        f   = ((k % (R * n)) == 0);
        if (p != R - 1) begin
            a[dig] = 1'b0;
            dark   = mbl[inst][dig];
            if (lz_en && dig != 0) begin
                allz = 1'b1;
                for (int j = dig; j < n; j++)
                    if (mval[inst][j] != 4'd0 || mbl[inst][j]) allz = 1'b0;
                if (allz) dark = 1'b1;
            end
            s = dark ? 7'h7F : ~dec_tab[mval[inst][dig]];
            d = ~mdp[inst][dig];
        end
    endfunction

    task automatic clear_model(input int inst);
        for (int j = 0; j < 16; j++) begin
            mval[inst][j] = 4'd0;
            mdp[inst][j]  = 1'b0;
            mbl[inst][j]  = 1'b0;
        end
    endtask

    // Predict the outputs of the coming posedge, update the model, then advance to the negedge.
    task automatic step();
        exp_t        e;
        logic [15:0] a;
        logic [6:0]  s;
        logic        d, f;
        int          n;
        if (rst) begin
            k = 0;
            clear_model(0);
            clear_model(1);
            e = '{an8: 8'hFF, seg8: 7'h7F, dp8: 1'b1, fd8: 1'b0,
                  an6: 6'h3F, seg6: 7'h7F, dp6: 1'b1, fd6: 1'b0, k: 0};
        end else begin
            k++;
            e.k = k;
            model_out(0, a, s, d, f);
            e.an8 = a[7:0]; e.seg8 = s; e.dp8 = d; e.fd8 = f;
            model_out(1, a, s, d, f);
            e.an6 = a[5:0]; e.seg6 = s; e.dp6 = d; e.fd6 = f;
            for (int inst = 0; inst < 2; inst++) begin
                n = (inst == 0) ? 8 : 6;
                if (clr) clear_model(inst);
                if (wr_en && int'(wr_sel) < n) begin
                    mval[inst][wr_sel] = wr_data;
                    mdp[inst][wr_sel]  = wr_dp;
                    mbl[inst][wr_sel]  = wr_blank;
                end
            end
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int sel, input int data, input bit d, input bit b);
        wr_en    = 1'b1;
        wr_sel   = 3'(sel);
        wr_data  = 4'(data);
        wr_dp    = d;
        wr_blank = b;
        step();
        wr_en    = 1'b0;
        wr_dp    = 1'b0;
        wr_blank = 1'b0;
    endtask

    task automatic chk(input string name, input int kk, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%h expected=%h", name, kk, act, exp);
        end
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_dut8", k, {15'd0, an8, seg8, dp8, fd8}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        chk("rst_async_dut6", k, {17'd0, an6, seg6, dp6, fd6}, {17'd0, 6'h3F, 7'h7F, 1'b1, 1'b0});
        idle(3);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow got=empty expected=entry");
            end else begin
                e = q.pop_front();
                chk("out_dut8", e.k, {15'd0, an8, seg8, dp8, fd8}, {15'd0, e.an8, e.seg8, e.dp8, e.fd8});
                chk("out_dut6", e.k, {17'd0, an6, seg6, dp6, fd6}, {17'd0, e.an6, e.seg6, e.dp6, e.fd6});
            end
        end
    end

    initial begin : driver
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; wr_dp = 1'b0;
        wr_blank = 1'b0; clr = 1'b0; lz_en = 1'b0;
        clear_model(0);
        clear_model(1);
        idle(3);
        rst = 1'b0;
        idle(2);
        for (int i = 0; i < 8; i++) wr(i, i, 1'b0, 1'b0);
        idle(40);
        for (int i = 0; i < 8; i++) wr(i, 8 + i, 1'b0, 1'b0);
        idle(36);
        wr(4, 9, 1'b1, 1'b1);
        idle(32);
        clr = 1'b1;
        wr(3, 5, 1'b0, 1'b0);
        clr = 1'b0;
        idle(32);
        clr = 1'b1; step(); clr = 1'b0;
        wr(2, 3, 1'b0, 1'b0);
        wr(1, 0, 1'b0, 1'b0);
        wr(0, 5, 1'b0, 1'b0);
        lz_en = 1'b1;
        idle(32);
        clr = 1'b1; step(); clr = 1'b0;
        idle(32);
        lz_en = 1'b0;
        wr(7, 9, 1'b1, 1'b0);
        wr(6, 10, 1'b0, 1'b0);
        idle(32);
        for (int i = 0; i < 400; i++) begin
            wr_en    = ($urandom_range(0, 9) < 4);
            wr_sel   = 3'($urandom_range(0, 7));
            wr_data  = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(0, 15));
            wr_dp    = 1'($urandom_range(0, 1));
            wr_blank = ($urandom_range(0, 9) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) lz_en = ~lz_en;
            step();
        end
        wr_en = 1'b0; clr = 1'b0; wr_dp = 1'b0; wr_blank = 1'b0; lz_en = 1'b0;
        wr(5, 6, 1'b0, 1'b0);
        idle(9);
        mid_reset();
        idle(40);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
